hazard_ctrl: RTL



---
 rtl/hazard_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage pipeline: operand forwarding selects,
// load-use / RAW stall and branch flush controls, memory-wait freeze FSM, and statistics.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        fwd_en,
    input  logic [4:0]  id_src1,
    input  logic [4:0]  id_src2,
    input  logic        id_two_src,
    input  logic        id_br_taken,
    input  logic [4:0]  exe_src1,
    input  logic [4:0]  exe_src2,
    input  logic [4:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_r_en,
    input  logic [4:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic [4:0]  wb_dest,
    input  logic        wb_wb_en,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic [1:0]  sel_src1,
    output logic [1:0]  sel_src2,
    output logic        freeze_pc,
    output logic        freeze_ifid,
    output logic        bubble_idex,
    output logic        flush_ifid,
    output logic        freeze_all,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0]  SEL_RF  = 2'b00;
    localparam logic [1:0]  SEL_MEM = 2'b01;
    localparam logic [1:0]  SEL_WB  = 2'b10;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t state;
    state_t next_state;
    logic   haz;
    logic   haz_src1;
    logic   haz_src2;

    // Register 0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dest,
                                       input logic en);
        return en && (src != 5'd0) && (src == dest);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (reg_match(src, mem_dest, mem_wb_en)) return SEL_MEM;
        if (reg_match(src, wb_dest, wb_wb_en))   return SEL_WB;
        return SEL_RF;
    endfunction

    function automatic logic src_haz(input logic [4:0] src);
        if (fwd_en)
            return reg_match(src, exe_dest, exe_wb_en && exe_mem_r_en);
        return reg_match(src, exe_dest, exe_wb_en) || reg_match(src, mem_dest, mem_wb_en);
    endfunction

    always_comb begin
        sel_src1 = SEL_RF;
        sel_src2 = SEL_RF;
        if (fwd_en) begin
            sel_src1 = fwd_sel(exe_src1);
            sel_src2 = fwd_sel(exe_src2);
        end
    end

    assign haz_src1 = src_haz(id_src1);
    assign haz_src2 = id_two_src && src_haz(id_src2);
    assign haz      = haz_src1 || haz_src2;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; combinational blocks use blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: every output of this block is assigned a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        freeze_all = 1'b0;
        unique case (state)
            IDLE: if (mem_req && !mem_ready) begin
                next_state = WAIT;
                freeze_all = 1'b1;
            end
            WAIT: if (mem_ready) next_state = DONE;
                  else           freeze_all = 1'b1;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A hazard outranks a taken branch: the branch was resolved with stale operands.
    always_comb begin
        freeze_pc   = 1'b0;
        freeze_ifid = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        if (!freeze_all) begin
            if (haz) begin
                freeze_pc   = 1'b1;
                freeze_ifid = 1'b1;
                bubble_idex = 1'b1;
            end else if (id_br_taken) begin
                flush_ifid  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((freeze_all || haz) && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 16'd1;
            if (flush_ifid && flush_count != CNT_MAX)
                flush_count <= flush_count + 16'd1;
        end
    end

endmodule
